input_port_controller: RTL and testbench

//  Reader side of the board I/O path. The display path lets the CPU write values out.

---
 rtl/io_pkg.sv | 15 +
 rtl/button_debouncer.sv | 54 +++++
 rtl/input_port_controller.sv | 102 ++++++++++
 tb/tb_input_port_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the board I/O path.
// State encodings and default word widths.
package io_pkg;

   localparam int DATA_WIDTH_DEF   = 32;
   localparam int SWITCH_WIDTH_DEF = 18;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      ARMED        = 2'd1,
      CAPTURE      = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_e;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stability counter and rising-edge pulse.
// Shared by the confirm and debug button paths.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] count_q, count_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;

   always_comb begin
      sync_d  = {sync_q[0], raw};
      count_d = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      // Only a disagreement with the debounced level advances the count
      if (sync_q[1] != level_q) begin
         if (count_q == LAST) begin
            level_d = ~level_q;
            rise_d  = ~level_q;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q  <= '0;
         count_q <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         count_q <= count_d;
         level_q <= level_d;
         rise_q  <= rise_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/input_port_controller.sv
// Switch reader for the IN instruction: debounced confirm,
// PC stall while pending, one-cycle valid strobe on capture.
module input_port_controller
   import io_pkg::*;
#(
   parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int SWITCH_WIDTH    = SWITCH_WIDTH_DEF,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter bit SIGN_EXTEND     = 1'b1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [SWITCH_WIDTH-1:0] switches,
   input  logic                    confirm_button,
   input  logic                    read_request,
   output logic [DATA_WIDTH-1:0]   read_data,
   output logic                    data_valid,
   output logic                    stall,
   output logic                    waiting
);

   function automatic logic [DATA_WIDTH-1:0] extend(
      input logic [SWITCH_WIDTH-1:0] sw
   );
      logic fill;
      fill = SIGN_EXTEND & sw[SWITCH_WIDTH-1];
      return {{(DATA_WIDTH-SWITCH_WIDTH){fill}}, sw};
   endfunction

   logic btn_level;
   logic btn_rise;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_dbc (
      .clock(clock),
      .reset(reset),
      .raw  (confirm_button),
      .level(btn_level),
      .rise (btn_rise)
   );

   state_e                  state_q, state_d;
   logic [SWITCH_WIDTH-1:0] sw_q, sw_d;
   logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
   logic                    data_valid_q, data_valid_d;
   logic                    waiting_q, waiting_d;

   always_comb begin
      state_d      = state_q;
      sw_d         = switches;
      read_data_d  = read_data_q;
      data_valid_d = 1'b0;
      waiting_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (read_request)
               state_d = btn_rise ? CAPTURE : ARMED;
         end
         ARMED: begin
            if (!read_request)
               state_d = IDLE;
            else if (btn_rise)
               state_d = CAPTURE;
         end
         CAPTURE: state_d = WAIT_RELEASE;
         WAIT_RELEASE: begin
            if (!btn_level)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Outputs are registered against the state being entered
      if (state_d == CAPTURE) begin
         read_data_d  = extend(sw_q);
         data_valid_d = 1'b1;
      end
      waiting_d = (state_d == ARMED);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         sw_q         <= '0;
         read_data_q  <= '0;
         data_valid_q <= 1'b0;
         waiting_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sw_q         <= sw_d;
         read_data_q  <= read_data_d;
         data_valid_q <= data_valid_d;
         waiting_q    <= waiting_d;
      end
   end

   assign read_data  = read_data_q;
   assign data_valid = data_valid_q;
   assign waiting    = waiting_q;
   assign stall      = read_request & ~data_valid_q;

endmodule

// File: tb/tb_input_port_controller.sv
// Directed bench for input_port_controller, sign- and
// zero-extending instances driven in parallel.
module tb_input_port_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic [17:0] switches;
   logic        confirm_button;
   logic        read_request;

   logic [31:0] rd_se, rd_ze;
   logic        dv_se, dv_ze;
   logic        stall_se, stall_ze;
   logic        wait_se, wait_ze;

   int n_checks = 0;
   int n_fail   = 0;
   int nv;

   always #5 clock = ~clock;

   input_port_controller #(
      .DATA_WIDTH(32), .SWITCH_WIDTH(18),
      .DEBOUNCE_CYCLES(4), .SIGN_EXTEND(1'b1)
   ) dut_se (
      .clock(clock), .reset(reset), .switches(switches),
      .confirm_button(confirm_button), .read_request(read_request),
      .read_data(rd_se), .data_valid(dv_se),
      .stall(stall_se), .waiting(wait_se)
   );

   input_port_controller #(
      .DATA_WIDTH(32), .SWITCH_WIDTH(18),
      .DEBOUNCE_CYCLES(4), .SIGN_EXTEND(1'b0)
   ) dut_ze (
      .clock(clock), .reset(reset), .switches(switches),
      .confirm_button(confirm_button), .read_request(read_request),
      .read_data(rd_ze), .data_valid(dv_ze),
      .stall(stall_ze), .waiting(wait_ze)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Assumes ARMED with request high; press, capture, then release.
   task automatic capture(input string tag, input logic [17:0] sw,
                          input logic [31:0] exp_se,
                          input logic [31:0] exp_ze);
      switches = sw;
      confirm_button = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check({tag, "_dv_early"}, {31'd0, dv_se}, 32'd0);
         check({tag, "_wait"}, {31'd0, wait_se}, 32'd1);
         check({tag, "_stall_pend"}, {31'd0, stall_se}, 32'd1);
      end
      tick();
      check({tag, "_dv"}, {31'd0, dv_se}, 32'd1);
      check({tag, "_dv_ze"}, {31'd0, dv_ze}, 32'd1);
      check({tag, "_stall_dv"}, {31'd0, stall_se}, 32'd0);
      check({tag, "_rd_se"}, rd_se, exp_se);
      check({tag, "_rd_ze"}, rd_ze, exp_ze);
      check({tag, "_wait_off"}, {31'd0, wait_se}, 32'd0);
      tick();
      check({tag, "_dv_once"}, {31'd0, dv_se}, 32'd0);
      check({tag, "_stall_hold"}, {31'd0, stall_se}, 32'd1);
      confirm_button = 1'b0;
      read_request = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check({tag, "_rd_hold"}, rd_se, exp_se);
      check({tag, "_idle_stall"}, {31'd0, stall_ze}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      switches = '0;
      confirm_button = 1'b0;
      read_request = 1'b0;

      // 1: reset with bouncing button
      for (int i = 0; i < 3; i++) begin
         confirm_button = ~confirm_button;
         tick();
         check("rst_rd_se", rd_se, 32'd0);
         check("rst_rd_ze", rd_ze, 32'd0);
         check("rst_dv", {31'd0, dv_se | dv_ze}, 32'd0);
         check("rst_stall", {31'd0, stall_se | stall_ze}, 32'd0);
         check("rst_wait", {31'd0, wait_se | wait_ze}, 32'd0);
      end
      reset = 1'b0;
      confirm_button = 1'b0;
      tick();
      tick();

      // 2: basic capture
      read_request = 1'b1;
      tick();
      check("t2_armed_wait", {31'd0, wait_ze}, 32'd1);
      capture("t2", 18'h00005, 32'h00000005, 32'h00000005);

      // 3: extension of MSB
      read_request = 1'b1;
      tick();
      capture("t3", 18'h20001, 32'hFFFE0001, 32'h00020001);

      // 4: bounce shorter than the debounce window
      read_request = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) begin
         confirm_button = (i % 4) >= 2;
         tick();
         check("t4_bounce_dv", {31'd0, dv_se}, 32'd0);
         check("t4_bounce_stall", {31'd0, stall_se}, 32'd1);
      end
      confirm_button = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      switches = 18'h1ABCD;
      confirm_button = 1'b1;
      nv = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         nv += int'(dv_se);
      end
      check("t4_one_dv", nv, 32'd1);
      check("t4_rd_se", rd_se, 32'h0001ABCD);
      check("t4_rd_ze", rd_ze, 32'h0001ABCD);
      confirm_button = 1'b0;
      read_request = 1'b0;
      for (int i = 0; i < 8; i++) tick();

      // 5: button already held when the request arrives
      confirm_button = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      read_request = 1'b1;
      nv = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         nv += int'(dv_se);
      end
      check("t5_no_capture", nv, 32'd0);
      check("t5_stall", {31'd0, stall_se}, 32'd1);
      check("t5_wait", {31'd0, wait_se}, 32'd1);
      confirm_button = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("t5_release_dv", {31'd0, dv_se}, 32'd0);
      end
      capture("t5", 18'h00003, 32'h00000003, 32'h00000003);

      // 6: reset in the middle of a debounce
      read_request = 1'b1;
      switches = 18'h00015;
      tick();
      confirm_button = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      confirm_button = 1'b0;
      tick();
      reset = 1'b0;
      check("t6_rd_se", rd_se, 32'd0);
      check("t6_rd_ze", rd_ze, 32'd0);
      check("t6_dv", {31'd0, dv_se}, 32'd0);
      check("t6_wait", {31'd0, wait_se}, 32'd0);
      check("t6_stall", {31'd0, stall_se}, 32'd1);
      check("t6_count", 32'(dut_se.u_dbc.count_q), 32'd0);
      nv = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         nv += int'(dv_se) + int'(dv_ze);
      end
      check("t6_no_dv", nv, 32'd0);
      check("t6_rd_kept", rd_se, 32'd0);
      read_request = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
